// File: rtl/phase_a_sched.sv
// Round-robin front end sharing one phase_a reduction unit among NREQ requesters.
// Optional watchdog with rsp_err output: define PHASE_A_SCHED_TMO_EN.
module phase_a_sched #(
    parameter int SIZE  = 3072,
    parameter int RADIX = 54,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int TMO   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_a,
    output logic [NREQ-1:0]      req_ready,
    input  logic [SIZE-1:0]      cfg_m,
    input  logic [SIZE+1:0]      cfg_m_n,
    input  logic [RADIX+1:0]     cfg_m_prime,
    output logic [SIZE-1:0]      pa_a,
    output logic [SIZE-1:0]      pa_m,
    output logic [SIZE+1:0]      pa_m_n,
    output logic [RADIX+1:0]     pa_m_prime,
    output logic                 pa_en,
    input  logic [SIZE-1:0]      pa_new_a,
    input  logic                 pa_en_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [SIZE-1:0]      rsp_data,
    input  logic                 rsp_ready,
`ifdef PHASE_A_SCHED_TMO_EN
    output logic                 rsp_err,
`endif
    output logic                 err_stray,
    output logic [15:0]          done_cnt
);

    if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_bad_cfg
        $error("phase_a_sched: NREQ must be 2..8 and TMO >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e          state_q;
    logic [IDW-1:0]  last_q;
    logic [IDW-1:0]  cur_id_q;
    logic [SIZE-1:0] pa_a_q;
    logic            pa_en_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [SIZE-1:0] rsp_data_q;
    logic            err_stray_q;
    logic [15:0]     done_cnt_q;

    logic [IDW-1:0]  gnt_id_d;
    logic [IDW-1:0]  cand_d;
    logic            gnt_any_d;

`ifdef PHASE_A_SCHED_TMO_EN
    localparam int WW = $clog2(TMO + 1);
    logic [WW-1:0] wdog_q;
    logic          rsp_err_q;
    assign rsp_err = rsp_err_q;
`endif

    // Scan last+1, last+2, ... so the previous winner gets lowest priority
    always_comb begin
        gnt_any_d = 1'b0;
        gnt_id_d  = '0;
        cand_d    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_d = IDW'((int'(last_q) + k) % NREQ);
            if (!gnt_any_d && req_valid[cand_d]) begin
                gnt_any_d = 1'b1;
                gnt_id_d  = cand_d;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_any_d) begin
            req_ready[gnt_id_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            cur_id_q    <= '0;
            pa_a_q      <= '0;
            pa_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            err_stray_q <= 1'b0;
            done_cnt_q  <= '0;
`ifdef PHASE_A_SCHED_TMO_EN
            wdog_q      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            if (pa_en_out && state_q != WAIT) begin
                err_stray_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (gnt_any_d) begin
                        pa_a_q   <= req_a[gnt_id_d*SIZE +: SIZE];
                        cur_id_q <= gnt_id_d;
                        last_q   <= gnt_id_d;
                        pa_en_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    pa_en_q <= 1'b0;
                    state_q <= WAIT;
`ifdef PHASE_A_SCHED_TMO_EN
                    wdog_q  <= '0;
`endif
                end
                WAIT: begin
                    if (pa_en_out) begin
                        rsp_data_q  <= pa_new_a;
                        rsp_id_q    <= cur_id_q;
                        rsp_valid_q <= 1'b1;
                        done_cnt_q  <= done_cnt_q + 16'd1;
                        state_q     <= RESP;
`ifdef PHASE_A_SCHED_TMO_EN
                        rsp_err_q   <= 1'b0;
                    end else if (wdog_q == WW'(TMO - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_id_q    <= cur_id_q;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wdog_q      <= wdog_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pa_a       = pa_a_q;
    assign pa_en      = pa_en_q;
    assign pa_m       = cfg_m;
    assign pa_m_n     = cfg_m_n;
    assign pa_m_prime = cfg_m_prime;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign err_stray  = err_stray_q;
    assign done_cnt   = done_cnt_q;

endmodule
